// File: rtl/minitb_ahb_slave_mem_pkg.sv
// Shared AHB-lite definitions for the miniTB slave memory and master BFM.
// Holds the htrans encodings, the slave FSM states and a transfer-type helper.
package minitb_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LAST
  } state_t;

  // Only NONSEQ and SEQ carry a real address phase.
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/minitb_ahb_slave_mem_if.sv
// AHB-lite bus bundle between the miniTB master BFM and the slave memory.
interface minitb_ahb_slave_mem_if #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
);
  logic [1:0]           htrans;
  logic [addrWidth-1:0] haddr;
  logic                 hwrite;
  logic [dataWidth-1:0] hwdata;
  logic                 hready;
  logic [dataWidth-1:0] hrdata;

  modport master (
    output htrans, haddr, hwrite, hwdata,
    input  hready, hrdata
  );

  modport slave (
    input  htrans, haddr, hwrite, hwdata,
    output hready, hrdata
  );
endinterface

// File: rtl/minitb_ahb_slave_mem_ram.sv
// Single-port word array: synchronous write, combinational read. Not reset.
module minitb_ahb_ram #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addrWidth-1:0] waddr,
  input  logic [dataWidth-1:0] wdata,
  input  logic [addrWidth-1:0] raddr,
  output logic [dataWidth-1:0] rdata
);
  logic [dataWidth-1:0] mem [0:(1<<addrWidth)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/minitb_ahb_slave_mem.sv
// AHB-lite slave memory: captures address phases, inserts waitStates wait
// cycles on hready, commits writes leaving LAST and returns reads in LAST.
module minitb_ahb_slave_mem
  import minitb_ahb_pkg::*;
#(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 32,
  parameter int waitStates = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  minitb_ahb_slave_mem_if.slave  ahb
);
  localparam logic [2:0] WAIT_INIT = 3'(waitStates);

  state_t               state_q;
  logic [2:0]           cnt_q;
  logic                 hready_q;
  logic [addrWidth-1:0] addr_q;
  logic                 write_q;
  logic                 accept;
  logic                 ram_we;
  logic [dataWidth-1:0] ram_rdata;

  // hready_q is the only qualifier, so htrans is ignored while a wait is pending.
  assign accept = hready_q && htrans_active(ahb.htrans);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hready_q <= 1'b1;
      addr_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_LAST: begin
          if (accept) begin
            addr_q  <= ahb.haddr;
            write_q <= ahb.hwrite;
            cnt_q   <= WAIT_INIT;
            if (WAIT_INIT == 3'd0) begin
              state_q  <= S_LAST;
              hready_q <= 1'b1;
            end else begin
              state_q  <= S_WAIT;
              hready_q <= 1'b0;
            end
          end else begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_q  <= S_LAST;
            hready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
        end
      endcase
    end
  end

  // The write lands on the edge leaving LAST, which is also the edge that
  // opens a following read's data phase, so no bypass path is needed.
  assign ram_we = (state_q == S_LAST) && write_q;

  minitb_ahb_ram #(
    .addrWidth (addrWidth),
    .dataWidth (dataWidth)
  ) u_ram (
    .clk   (hclk),
    .we    (ram_we),
    .waddr (addr_q),
    .wdata (ahb.hwdata),
    .raddr (addr_q),
    .rdata (ram_rdata)
  );

  assign ahb.hready = hready_q;
  assign ahb.hrdata = ((state_q == S_LAST) && !write_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Directed bench for minitb_ahb_slave_mem with three instances (0, 2 and 3
// wait states); sel routes htrans to one instance, the others see IDLE.
module tb_minitb_ahb_slave_mem;
  import minitb_ahb_pkg::*;

  logic        clk;
  logic        hresetn;
  logic [1:0]  sel;
  logic [1:0]  htrans;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        cur_hready;
  logic [31:0] cur_hrdata;
  int          n_checks;
  int          n_errors;

  minitb_ahb_slave_mem_if #(.addrWidth(8), .dataWidth(32)) bus0 ();
  minitb_ahb_slave_mem_if #(.addrWidth(8), .dataWidth(32)) bus2 ();
  minitb_ahb_slave_mem_if #(.addrWidth(8), .dataWidth(32)) bus3 ();

  assign bus0.htrans = (sel == 2'd0) ? htrans : 2'b00;
  assign bus2.htrans = (sel == 2'd2) ? htrans : 2'b00;
  assign bus3.htrans = (sel == 2'd3) ? htrans : 2'b00;
  assign bus0.haddr  = haddr;
  assign bus2.haddr  = haddr;
  assign bus3.haddr  = haddr;
  assign bus0.hwrite = hwrite;
  assign bus2.hwrite = hwrite;
  assign bus3.hwrite = hwrite;
  assign bus0.hwdata = hwdata;
  assign bus2.hwdata = hwdata;
  assign bus3.hwdata = hwdata;

  always_comb begin
    cur_hready = bus0.hready;
    cur_hrdata = bus0.hrdata;
    case (sel)
      2'd2: begin cur_hready = bus2.hready; cur_hrdata = bus2.hrdata; end
      2'd3: begin cur_hready = bus3.hready; cur_hrdata = bus3.hrdata; end
      default: ;
    endcase
  end

  minitb_ahb_slave_mem #(.addrWidth(8), .dataWidth(32), .waitStates(0)) dut0 (
    .hclk(clk), .hresetn(hresetn), .ahb(bus0)
  );
  minitb_ahb_slave_mem #(.addrWidth(8), .dataWidth(32), .waitStates(2)) dut2 (
    .hclk(clk), .hresetn(hresetn), .ahb(bus2)
  );
  minitb_ahb_slave_mem #(.addrWidth(8), .dataWidth(32), .waitStates(3)) dut3 (
    .hclk(clk), .hresetn(hresetn), .ahb(bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic addr_phase(input logic [1:0] t, input logic w, input logic [7:0] a);
    htrans = t;
    hwrite = w;
    haddr  = a;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    hresetn  = 1'b0;
    sel      = 2'd0;
    htrans   = 2'b00;
    haddr    = '0;
    hwrite   = 1'b0;
    hwdata   = '0;

    // Reset values
    step();
    step();
    check("rst_hready0", 32'(bus0.hready), 32'd1);
    check("rst_hready2", 32'(bus2.hready), 32'd1);
    check("rst_hready3", 32'(bus3.hready), 32'd1);
    check("rst_hrdata0", bus0.hrdata, 32'h0);
    check("rst_state0", 32'(dut0.state_q), 32'(S_IDLE));
    hresetn = 1'b1;

    // W=0: write 0x10 then read 0x10
    addr_phase(2'b10, 1'b1, 8'h10);
    step();
    hwdata = 32'hDEADBEEF;
    addr_phase(2'b10, 1'b0, 8'h10);
    check("w0_wr_hready", 32'(cur_hready), 32'd1);
    check("w0_wr_hrdata", cur_hrdata, 32'h0);
    step();
    addr_phase(2'b00, 1'b0, 8'h00);
    check("w0_rd_hready", 32'(cur_hready), 32'd1);
    check("w0_rd_data", cur_hrdata, 32'hDEADBEEF);
    step();
    check("w0_idle_hrdata", cur_hrdata, 32'h0);
    check("w0_idle_hready", 32'(cur_hready), 32'd1);

    // W=0: back-to-back write/read, then write another word and re-read
    addr_phase(2'b10, 1'b1, 8'h20);
    step();
    hwdata = 32'h12345678;
    addr_phase(2'b11, 1'b0, 8'h20);
    step();
    check("b2b_rd20_a", cur_hrdata, 32'h12345678);
    addr_phase(2'b10, 1'b1, 8'h21);
    step();
    hwdata = 32'hA5A5A5A5;
    check("b2b_wr21_hrdata", cur_hrdata, 32'h0);
    addr_phase(2'b10, 1'b0, 8'h20);
    step();
    check("b2b_rd20_b", cur_hrdata, 32'h12345678);
    addr_phase(2'b10, 1'b0, 8'h21);
    step();
    check("b2b_rd21", cur_hrdata, 32'hA5A5A5A5);
    check("b2b_hready", 32'(cur_hready), 32'd1);
    addr_phase(2'b00, 1'b0, 8'h00);
    step();

    // W=2: write 0x05, hready low two cycles, commit one edge after LAST
    sel = 2'd2;
    addr_phase(2'b10, 1'b1, 8'h05);
    step();
    addr_phase(2'b00, 1'b0, 8'h00);
    hwdata = 32'hCAFEF00D;
    check("w2_wait1", 32'(cur_hready), 32'd0);
    step();
    check("w2_wait2", 32'(cur_hready), 32'd0);
    check("w2_mem_pre1", 32'(dut2.u_ram.mem[5] === 32'hCAFEF00D), 32'd0);
    step();
    check("w2_last", 32'(cur_hready), 32'd1);
    check("w2_mem_pre2", 32'(dut2.u_ram.mem[5] === 32'hCAFEF00D), 32'd0);
    step();
    check("w2_mem_post", dut2.u_ram.mem[5], 32'hCAFEF00D);
    check("w2_idle_hready", 32'(cur_hready), 32'd1);
    hwdata = 32'h0;
    addr_phase(2'b10, 1'b0, 8'h05);
    step();
    addr_phase(2'b00, 1'b0, 8'h00);
    check("w2_rd_wait1", 32'(cur_hready), 32'd0);
    check("w2_rd_wait_data", cur_hrdata, 32'h0);
    step();
    check("w2_rd_wait2", 32'(cur_hready), 32'd0);
    step();
    check("w2_rd_last", 32'(cur_hready), 32'd1);
    check("w2_rd_data", cur_hrdata, 32'hCAFEF00D);
    step();
    check("w2_rd_after", cur_hrdata, 32'h0);

    // IDLE and BUSY transfers are never accepted
    sel = 2'd0;
    hwdata = 32'hFFFFFFFF;
    for (int i = 0; i < 10; i++) begin
      addr_phase(2'b00, 1'b1, 8'h10);
      step();
      check("idle_hready", 32'(cur_hready), 32'd1);
      check("idle_hrdata", cur_hrdata, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      addr_phase(2'b01, 1'b1, 8'h10);
      step();
      check("busy_hready", 32'(cur_hready), 32'd1);
      check("busy_hrdata", cur_hrdata, 32'h0);
      check("busy_state", 32'(dut0.state_q), 32'(S_IDLE));
    end
    check("busy_mem10", dut0.u_ram.mem[16], 32'hDEADBEEF);
    addr_phase(2'b10, 1'b0, 8'h10);
    step();
    addr_phase(2'b00, 1'b0, 8'h00);
    check("busy_rd10", cur_hrdata, 32'hDEADBEEF);
    step();

    // W=3: complete write 0x30, then reset during the second write's wait
    sel = 2'd3;
    addr_phase(2'b10, 1'b1, 8'h30);
    step();
    addr_phase(2'b00, 1'b0, 8'h00);
    hwdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      check("w3_wait", 32'(cur_hready), 32'd0);
      step();
    end
    check("w3_last", 32'(cur_hready), 32'd1);
    step();
    check("w3_mem_first", dut3.u_ram.mem[48], 32'h11111111);
    addr_phase(2'b10, 1'b1, 8'h30);
    step();
    addr_phase(2'b00, 1'b0, 8'h00);
    hwdata = 32'h22222222;
    check("w3_rst_pre", 32'(cur_hready), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    check("w3_rst_hready", 32'(cur_hready), 32'd1);
    check("w3_rst_state", 32'(dut3.state_q), 32'(S_IDLE));
    check("w3_rst_hrdata", cur_hrdata, 32'h0);
    step();
    hresetn = 1'b1;
    step();
    check("w3_post_hready", 32'(cur_hready), 32'd1);
    check("w3_post_mem", dut3.u_ram.mem[48], 32'h11111111);
    addr_phase(2'b10, 1'b0, 8'h30);
    step();
    addr_phase(2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("w3_rd_wait", 32'(cur_hready), 32'd0);
      step();
    end
    check("w3_rd_last", 32'(cur_hready), 32'd1);
    check("w3_rd_data", cur_hrdata, 32'h11111111);
    step();
    check("w3_rd_after", cur_hrdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete within 20000 time units");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/minitb_ahb_slave_mem.md
# minitb_ahb_slave_mem

Synthesizable AHB-lite slave memory that sits directly downstream of the miniTB AHB master BFM and answers its IDLE/NONSEQ basic_write and basic_read transfers. It captures each address phase, optionally inserts a fixed number of wait states on hready, commits write data at the end of the data phase, and returns read data during the final data-phase cycle. It serves as the default target memory in miniTB AHB benches.

## Interface
- addrWidth, 8: haddr width. Each haddr value selects one dataWidth word, giving 2**addrWidth words. No byte addressing.
- dataWidth, 32: hwdata/hrdata width.
- waitStates, 0: wait cycles per transfer, legal range 0..7. Any nonzero value requires a master that honours hready.
- hclk, input, 1: clock, rising-edge active.
- hresetn, input, 1: reset, asynchronous assert, active-low.
- htrans, input, 2: transfer type.
- haddr, input, addrWidth: address, sampled in the address phase.
- hwrite, input, 1: 1 = write, 0 = read, sampled in the address phase.
- hwdata, input, dataWidth: write data, sampled at the rising edge that ends the write data phase.
- hready, output, 1: transfer done / slave ready.
- hrdata, output, dataWidth: read data.

## Operation
- Accept rule: an address phase is accepted at a rising hclk edge when hready==1 and htrans is NONSEQ or SEQ.
  - On acceptance, register addr_q<=haddr, write_q<=hwrite and load the wait counter with waitStates.
  - IDLE and BUSY are never accepted.
  - htrans is ignored while hready==0; the master must hold its address phase.
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: data phase pending, hready=0.
  - LAST: final data-phase cycle, hready=1.
- FSM transitions:
  - IDLE -> LAST on accept when waitStates==0.
  - IDLE -> WAIT on accept when waitStates>0.
  - WAIT -> WAIT while the counter is >1; the counter decrements each edge.
  - WAIT -> LAST when the counter reaches 1.
  - LAST -> LAST on accept when waitStates==0 (back-to-back transfers).
  - LAST -> WAIT on accept when waitStates>0.
  - LAST -> IDLE when no transfer is accepted.
- Write: at the rising edge leaving LAST with write_q==1, mem[addr_q]<=hwdata (full word). hsize is not supported.
- Read: in LAST with write_q==0, hrdata = mem[addr_q] (combinational from the registered address). In every other cycle hrdata = 0.
- Write-then-read to the same address on consecutive transfers returns the new data. The write commits on the same edge that starts the read's data phase, so no forwarding is needed.
- Memory array is not reset; unwritten locations read X in simulation.

## Timing
- Reset (hresetn=0, asynchronous):
  - state=IDLE, counter=0, hready=1, hrdata=0.
  - addr_q and write_q cleared.
  - A pending write is dropped.
- Reset release: the first accept is possible at the first rising edge with hresetn==1.
- Latency with waitStates=W and the address accepted at edge N:
  - hready=0 from edge N to edge N+W (W cycles).
  - hready=1 in the cycle after edge N+W.
  - A write commits at edge N+W+1.
- With W=0, hready stays 1 throughout and a new transfer is accepted every cycle.
- hready is driven from registered state only; there is no combinational path from any input to hready.
- A reset asserted mid-WAIT or mid-LAST aborts the transfer, and hready returns to 1 immediately.

## Structure
- Package minitb_ahb_pkg holds:
  - htrans constants IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11, shared with the master BFM.
  - FSM enum state_t {S_IDLE, S_WAIT, S_LAST}.
- One natural sub-module, minitb_ahb_ram:
  - single-port array, 2**addrWidth x dataWidth.
  - synchronous write port (we, waddr, wdata), combinational read port (raddr, rdata).
- The top level holds the FSM, the wait counter, the address/control registers and hrdata muxing.

## Test plan
- waitStates=0: write 0x10<=0xDEADBEEF, then read 0x10 -> hrdata=0xDEADBEEF in the read data-phase cycle; hready stays 1 throughout.
- waitStates=0: back-to-back write 0x20<=0x12345678 immediately followed by read 0x20 -> read returns 0x12345678; write 0x21<=0xA5A5A5A5 followed by read 0x20 -> read returns 0x12345678.
- waitStates=2: write 0x05<=0xCAFEF00D accepted at edge N -> hready=0 for 2 cycles, 1 in the third, mem[0x05] updated at edge N+3; a later read of 0x05 returns 0xCAFEF00D.
- Idle and BUSY: 10 cycles of htrans=IDLE, then htrans=BUSY with hwrite=1 and haddr=0x10 -> no accepts, mem[0x10] unchanged, hrdata=0, hready=1.
- Reset mid-operation: waitStates=3, write 0x30<=0x11111111 completed, then write 0x30<=0x22222222 with hresetn pulsed low during WAIT -> hready=1 at once, state IDLE; a subsequent read of 0x30 returns 0x11111111.
